// File: rtl/laji_pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Drives pipeline register enables/clears, PC load, halt drain and stats.
module laji_pipeline_ctrl #(
  parameter int REG_W        = 5,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             ex_branch_taken,
  input  logic             ex_halt,
  input  logic             dm_req,
  input  logic             dm_ready,
  output logic             pc_en,
  output logic             en_vps1,
  output logic             en_vps2,
  output logic             en_vps3,
  output logic             en_vps4,
  output logic             clear_vps1,
  output logic             clear_vps2,
  output logic             clear_vps3,
  output logic             clear_vps4,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;
  localparam logic [1:0] HALTED   = 2'd3;

  localparam int DW = $clog2(DRAIN_CYCLES + 2);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [1:0]    eff;
  logic          ret_drain;
  logic          ret_drain_nx;
  logic [DW-1:0] drain_cnt;
  logic [DW-1:0] drain_nx;
  logic          stall_inc;
  logic          flush_inc;
  logic          mem_stall;
  logic          freeze;
  logic          load_use;

  assign mem_stall = dm_req && !dm_ready;
  assign freeze    = !en || mem_stall;
  assign halted    = (state == HALTED);

  assign load_use = ex_is_load && (ex_wreg != '0) &&
                    ((id_uses_rs && (id_rs == ex_wreg)) ||
                     (id_uses_rt && (id_rt == ex_wreg)));

  // MEM_WAIT behaves like the state it interrupted once memory answers
  assign eff = (state == MEM_WAIT) ? (ret_drain ? DRAIN : RUN) : state;

  always_comb begin
    pc_en        = 1'b0;
    en_vps1      = 1'b0;
    en_vps2      = 1'b0;
    en_vps3      = 1'b0;
    en_vps4      = 1'b0;
    clear_vps1   = 1'b0;
    clear_vps2   = 1'b0;
    clear_vps3   = 1'b0;
    clear_vps4   = 1'b0;
    state_nx     = state;
    ret_drain_nx = ret_drain;
    drain_nx     = drain_cnt;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (!rst_n) begin
      clear_vps1 = 1'b1;
      clear_vps2 = 1'b1;
      clear_vps3 = 1'b1;
      clear_vps4 = 1'b1;
    end else if (state == HALTED) begin
      state_nx = HALTED;
    end else if (freeze) begin
      if (mem_stall) begin
        state_nx     = MEM_WAIT;
        ret_drain_nx = (eff == DRAIN);
      end
    end else if (eff == DRAIN) begin
      clear_vps1 = 1'b1;
      clear_vps2 = 1'b1;
      en_vps3    = 1'b1;
      en_vps4    = 1'b1;
      drain_nx   = (drain_cnt == '0) ? '0 : drain_cnt - 1'b1;
      state_nx   = (drain_cnt <= DW'(1)) ? HALTED : DRAIN;
    end else if (ex_halt) begin
      clear_vps1 = 1'b1;
      clear_vps2 = 1'b1;
      en_vps3    = 1'b1;
      en_vps4    = 1'b1;
      state_nx   = DRAIN;
    end else if (ex_branch_taken) begin
      pc_en      = 1'b1;
      en_vps1    = 1'b1;
      en_vps2    = 1'b1;
      en_vps3    = 1'b1;
      en_vps4    = 1'b1;
      clear_vps1 = 1'b1;
      clear_vps2 = 1'b1;
      flush_inc  = 1'b1;
      state_nx   = RUN;
    end else if (load_use) begin
      en_vps2    = 1'b1;
      en_vps3    = 1'b1;
      en_vps4    = 1'b1;
      clear_vps2 = 1'b1;
      stall_inc  = 1'b1;
      state_nx   = RUN;
    end else begin
      pc_en    = 1'b1;
      en_vps1  = 1'b1;
      en_vps2  = 1'b1;
      en_vps3  = 1'b1;
      en_vps4  = 1'b1;
      state_nx = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_drain <= 1'b0;
      drain_cnt <= DW'(DRAIN_CYCLES);
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      ret_drain <= ret_drain_nx;
      drain_cnt <= drain_nx;
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_laji_pipeline_ctrl.sv
// Self-checking bench for laji_pipeline_ctrl: vector table,
// directed corner sequences and randomized run against a model.
module tb_laji_pipeline_ctrl;

  localparam int DRAIN = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [4:0] id_rs, id_rt, ex_wreg;
  logic       id_uses_rs, id_uses_rt, ex_is_load;
  logic       ex_branch_taken, ex_halt, dm_req, dm_ready;

  logic        pc_en, halted;
  logic        en_vps1, en_vps2, en_vps3, en_vps4;
  logic        clear_vps1, clear_vps2, clear_vps3, clear_vps4;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_en4, halted4;
  logic        e41, e42, e43, e44, c41, c42, c43, c44;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  bit     m_halted, m_drain;
  int     m_left;
  longint m_stall, m_flush, m_stall4, m_flush4;

  always #5 clk = ~clk;

  laji_pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_is_load(ex_is_load), .ex_wreg(ex_wreg),
    .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt),
    .dm_req(dm_req), .dm_ready(dm_ready),
    .pc_en(pc_en),
    .en_vps1(en_vps1), .en_vps2(en_vps2),
    .en_vps3(en_vps3), .en_vps4(en_vps4),
    .clear_vps1(clear_vps1), .clear_vps2(clear_vps2),
    .clear_vps3(clear_vps3), .clear_vps4(clear_vps4),
    .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  laji_pipeline_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_is_load(ex_is_load), .ex_wreg(ex_wreg),
    .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt),
    .dm_req(dm_req), .dm_ready(dm_ready),
    .pc_en(pc_en4),
    .en_vps1(e41), .en_vps2(e42), .en_vps3(e43), .en_vps4(e44),
    .clear_vps1(c41), .clear_vps2(c42),
    .clear_vps3(c43), .clear_vps4(c44),
    .halted(halted4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  typedef struct {
    bit         en;
    bit         dm_req;
    bit         dm_ready;
    bit         load;
    logic [4:0] wreg;
    logic [4:0] rs;
    logic [4:0] rt;
    bit         urs;
    bit         urt;
    bit         br;
    logic [9:0] exp;
  } vec_t;

  function automatic logic [9:0] obs();
    return {pc_en, en_vps1, en_vps2, en_vps3, en_vps4,
            clear_vps1, clear_vps2, clear_vps3, clear_vps4, halted};
  endfunction

  function automatic logic [9:0] obs4();
    return {pc_en4, e41, e42, e43, e44, c41, c42, c43, c44, halted4};
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit lu_now();
    return ex_is_load && ex_wreg != 0 &&
           ((id_uses_rs && id_rs == ex_wreg) ||
            (id_uses_rt && id_rt == ex_wreg));
  endfunction

  function automatic bit frozen_now();
    return !en || (dm_req && !dm_ready);
  endfunction

  // {pc, en1..4, clr1..4, halted}
  function automatic logic [9:0] model_out();
    if (m_halted) return 10'b0000000001;
    if (frozen_now()) return 10'b0000000000;
    if (m_drain || ex_halt) return 10'b0001111000;
    if (ex_branch_taken) return 10'b1111111000;
    if (lu_now()) return 10'b0011101000;
    return 10'b1111100000;
  endfunction

  task automatic model_reset();
    m_halted = 0;
    m_drain  = 0;
    m_left   = 0;
    m_stall  = 0;
    m_flush  = 0;
    m_stall4 = 0;
    m_flush4 = 0;
  endtask

  task automatic model_step();
    if (m_halted || frozen_now()) return;
    if (m_drain) begin
      m_left--;
      if (m_left <= 0) m_halted = 1;
    end else if (ex_halt) begin
      m_drain = 1;
      m_left  = DRAIN;
    end else if (ex_branch_taken) begin
      if (m_flush < 64'hFFFF_FFFF) m_flush++;
      if (m_flush4 < 15) m_flush4++;
    end else if (lu_now()) begin
      if (m_stall < 64'hFFFF_FFFF) m_stall++;
      if (m_stall4 < 15) m_stall4++;
    end
  endtask

  task automatic idle_inputs();
    en = 1; id_rs = 0; id_rt = 0; ex_wreg = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_is_load = 0;
    ex_branch_taken = 0; ex_halt = 0; dm_req = 0; dm_ready = 0;
  endtask

  // inputs set just after negedge; check, clock, advance model
  task automatic cycle(string nm);
    #1;
    chk({nm, "_out"}, obs(), model_out());
    chk({nm, "_out4"}, obs4(), model_out());
    chk({nm, "_stall"}, stall_cnt, m_stall);
    chk({nm, "_flush"}, flush_cnt, m_flush);
    chk({nm, "_stall4"}, stall_cnt4, m_stall4);
    chk({nm, "_flush4"}, flush_cnt4, m_flush4);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    #1;
    chk("rst_out", obs(), 10'b0000011110);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  vec_t tbl[10];

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();

    tbl[0] = '{1,0,0,0, 0, 0, 0,0,0,0, 10'b1111100000};
    tbl[1] = '{1,0,0,1, 8, 8, 0,1,0,0, 10'b0011101000};
    tbl[2] = '{1,0,0,1, 0, 0, 0,1,0,0, 10'b1111100000};
    tbl[3] = '{1,0,0,1, 3, 1, 3,0,1,0, 10'b0011101000};
    tbl[4] = '{1,0,0,1, 8, 8, 0,0,0,0, 10'b1111100000};
    tbl[5] = '{1,0,0,1, 8, 8, 0,1,0,1, 10'b1111111000};
    tbl[6] = '{0,0,0,0, 0, 0, 0,0,0,1, 10'b0000000000};
    tbl[7] = '{1,1,1,1, 5, 5, 0,1,0,0, 10'b0011101000};
    tbl[8] = '{1,1,0,0, 0, 0, 0,0,0,1, 10'b0000000000};
    tbl[9] = '{1,0,0,0, 0, 0, 0,0,0,0, 10'b1111100000};

    do_reset();
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_halted", halted, 0);

    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      en = tbl[i].en; dm_req = tbl[i].dm_req; dm_ready = tbl[i].dm_ready;
      ex_is_load = tbl[i].load; ex_wreg = tbl[i].wreg;
      id_rs = tbl[i].rs; id_rt = tbl[i].rt;
      id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt;
      ex_branch_taken = tbl[i].br;
      #1;
      chk($sformatf("tbl%0d", i), obs(), tbl[i].exp);
      cycle($sformatf("tblm%0d", i));
    end
    chk("tbl_stall", stall_cnt, 3);
    chk("tbl_flush", flush_cnt, 1);

    // three memory wait cycles, then ready completes a normal cycle
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      dm_req = 1; dm_ready = (i == 3);
      #1;
      chk("memw", obs(), (i == 3) ? 10'b1111100000 : 10'b0000000000);
      cycle("memw_m");
    end
    chk("memw_stall", stall_cnt, 3);

    // saturation of the narrow counters
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle_inputs();
      ex_is_load = 1; ex_wreg = 8; id_rs = 8; id_uses_rs = 1;
      cycle("sat");
    end
    chk("sat4", stall_cnt4, 15);
    chk("sat32", stall_cnt, 20);

    // asynchronous reset mid-stream, away from any clock edge
    idle_inputs();
    #2;
    rst_n = 0;
    #1;
    chk("arst_out", obs(), 10'b0000011110);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_stall4", stall_cnt4, 0);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // randomized blocks against the model
    for (int b = 0; b < 3; b++) begin
      do_reset();
      for (int i = 0; i < 600; i++) begin
        en = ($urandom_range(0, 9) != 0);
        dm_req = ($urandom_range(0, 3) == 0);
        dm_ready = $urandom_range(0, 1);
        ex_is_load = $urandom_range(0, 1);
        ex_wreg = 5'($urandom_range(0, 3));
        id_rs = 5'($urandom_range(0, 3));
        id_rt = 5'($urandom_range(0, 3));
        id_uses_rs = $urandom_range(0, 1);
        id_uses_rt = $urandom_range(0, 1);
        ex_branch_taken = ($urandom_range(0, 4) == 0);
        ex_halt = ($urandom_range(0, 149) == 0);
        cycle("rnd");
      end
    end

    // halt with branch, one memory wait inside the drain
    do_reset();
    idle_inputs();
    ex_halt = 1; ex_branch_taken = 1;
    #1;
    chk("halt_acc", obs(), 10'b0001111000);
    cycle("halt_m");
    idle_inputs();
    cycle("drain1");
    dm_req = 1; dm_ready = 0;
    #1;
    chk("drain_wait", obs(), 10'b0000000000);
    cycle("drain_w");
    idle_inputs();
    #1;
    chk("drain2", obs(), 10'b0001111000);
    cycle("drain2_m");
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      en = i[0];
      dm_req = i[1];
      ex_branch_taken = 1;
      #1;
      chk("halted", obs(), 10'b0000000001);
      cycle("halted_m");
    end
    chk("halt_flush", flush_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
